binary_window_3x3: RTL and testbench

//  Streaming 3x3 window generator for 1-bit (binarized) image data, one pixel per beat, raster order.

---
 rtl/binary_window_3x3.sv | 160 ++++++++++++++++
 tb/tb_binary_window_3x3.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_window_3x3.sv
// rtl/binary_window_3x3.sv - streaming 3x3 window generator for 1-bit raster pixels
// Optional popcount output enabled by defining WIN_POPCOUNT_EN.

module binary_window_3x3 #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_in,
    input  logic       pix_valid,
    input  logic       pix_sof,
    output logic       pix_ready,
    output logic [8:0] win_out,
    output logic       win_valid,
    input  logic       win_ready,
`ifdef WIN_POPCOUNT_EN
    output logic [3:0] win_popcnt,
`endif
    output logic       win_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [IMG_WIDTH-1:0] line1_q, line1_d;
    logic [IMG_WIDTH-1:0] line2_q, line2_d;
    logic [8:0]           arr_q, arr_d;
    logic [8:0]           arr_shift;
    logic [8:0]           wout_q, wout_d;
    logic                 wvalid_q, wvalid_d;
    logic                 wlast_q, wlast_d;
    logic [2:0]           new_col;
    logic                 accept, start, in_frame, emit, col_last, row_last;
`ifdef WIN_POPCOUNT_EN
    logic [3:0]           pc_q, pc_d;
`endif

    assign pix_ready = win_ready || !wvalid_q;
    assign win_out   = wout_q;
    assign win_valid = wvalid_q;
    assign win_last  = wlast_q;
`ifdef WIN_POPCOUNT_EN
    assign win_popcnt = pc_q;
`endif

    always_comb begin
        accept   = pix_valid && pix_ready;
        start    = accept && pix_sof;
        // Non-sof beats in IDLE are consumed but touch nothing.
        in_frame = accept && !pix_sof && (state_q != S_IDLE);
        col_last = (col_q == CW'(IMG_WIDTH - 1));
        row_last = (row_q == RW'(IMG_HEIGHT - 1));
        emit     = in_frame && (row_q >= RW'(2)) && (col_q >= CW'(2));

        // Column vector bit r: r=0 two rows up, r=1 one row up, r=2 current pixel.
        new_col  = {pix_in, line1_q[IMG_WIDTH-1], line2_q[IMG_WIDTH-1]};
        for (int r = 0; r < 3; r++) begin
            arr_shift[3*r]     = arr_q[3*r+1];
            arr_shift[3*r + 1] = arr_q[3*r+2];
            arr_shift[3*r + 2] = new_col[r];
        end

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        line1_d  = line1_q;
        line2_d  = line2_q;
        arr_d    = arr_q;
        wout_d   = wout_q;
        wvalid_d = wvalid_q;
        wlast_d  = wlast_q;

        if (start || in_frame) begin
            line1_d = {line1_q[IMG_WIDTH-2:0], pix_in};
            line2_d = {line2_q[IMG_WIDTH-2:0], line1_q[IMG_WIDTH-1]};
            arr_d   = arr_shift;
        end

        if (start) begin
            state_d = S_FILL;
            col_d   = CW'(1);
            row_d   = '0;
        end else if (in_frame) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (state_q == S_FILL && row_q == RW'(2) && col_q == CW'(2)) begin
                state_d = S_STREAM;
            end
            if (row_last && col_last) begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        end

        if (emit) begin
            wvalid_d = 1'b1;
            wout_d   = arr_shift;
            wlast_d  = row_last && col_last;
        end else if (win_ready) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
        end
    end

`ifdef WIN_POPCOUNT_EN
    always_comb begin
        pc_d = pc_q;
        if (emit) begin
            pc_d = '0;
            for (int i = 0; i < 9; i++) begin
                pc_d = pc_d + 4'(arr_shift[i]);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            line1_q  <= '0;
            line2_q  <= '0;
            arr_q    <= '0;
            wout_q   <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
`ifdef WIN_POPCOUNT_EN
            pc_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
            arr_q    <= arr_d;
            wout_q   <= wout_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
`ifdef WIN_POPCOUNT_EN
            pc_q     <= pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_binary_window_3x3.sv
// tb/tb_binary_window_3x3.sv - directed and random checks for binary_window_3x3

module tb_binary_window_3x3;

    typedef struct packed {
        logic [15:0]     frame;
        logic [3:0][8:0] w;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pix_in, pix_valid, pix_sof, pix_ready;
    logic [8:0] win_out;
    logic       win_valid, win_last;
    wire        win_ready;
    logic       ready_man, tog_mode, tog_q;
    assign win_ready = tog_mode ? tog_q : ready_man;

    logic       pix_in2, pix_valid2, pix_sof2, pix_ready2;
    logic [8:0] win_out2;
    logic       win_valid2, win_last2, win_ready2;
`ifdef WIN_POPCOUNT_EN
    logic [3:0] win_popcnt, win_popcnt2;
`endif

    binary_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready),
`ifdef WIN_POPCOUNT_EN
        .win_popcnt(win_popcnt),
`endif
        .win_last(win_last));

    binary_window_3x3 #(.IMG_WIDTH(28), .IMG_HEIGHT(28)) dut2 (
        .clk(clk), .rst(rst), .pix_in(pix_in2), .pix_valid(pix_valid2), .pix_sof(pix_sof2),
        .pix_ready(pix_ready2), .win_out(win_out2), .win_valid(win_valid2), .win_ready(win_ready2),
`ifdef WIN_POPCOUNT_EN
        .win_popcnt(win_popcnt2),
`endif
        .win_last(win_last2));

    int n_cmp = 0;
    int n_err = 0;
    int stall_seen = 0;
    int stall_bad = 0;
    int tog_cnt = 0;

    logic [8:0] got_w[$];
    logic       got_l[$];
    logic [3:0] got_pc[$];
    logic [8:0] got_w2[$];
    logic       got_l2[$];
    logic [3:0] got_pc2[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    initial begin
        tog_q = 1'b1;
        forever begin
            @(posedge clk); #1;
            tog_cnt++;
            if (tog_cnt % 2 == 0) tog_q = ~tog_q;
        end
    end

    initial begin
        win_ready2 = 1'b1;
        forever begin
            @(posedge clk); #1;
            win_ready2 = ($urandom_range(0, 99) < 60);
        end
    end

    // Transfers are captured mid-cycle; the handshake completes at the next posedge.
    initial begin
        logic       prev_stall;
        logic [8:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(win_valid && win_out == prev_out)) stall_bad++;
                if (win_valid && win_ready) begin
                    got_w.push_back(win_out);
                    got_l.push_back(win_last);
`ifdef WIN_POPCOUNT_EN
                    got_pc.push_back(win_popcnt);
`endif
                end
                if (win_valid && !win_ready) begin
                    stall_seen++;
                    if (pix_ready) stall_bad++;
                    prev_stall = 1'b1;
                    prev_out   = win_out;
                end else begin
                    prev_stall = 1'b0;
                end
                if (win_valid2 && win_ready2) begin
                    got_w2.push_back(win_out2);
                    got_l2.push_back(win_last2);
`ifdef WIN_POPCOUNT_EN
                    got_pc2.push_back(win_popcnt2);
`endif
                end
            end
        end
    end

    task automatic send_beat(input logic p, input logic sof);
        logic acc;
        int   guard;
        pix_valid = 1'b1; pix_in = p; pix_sof = sof;
        guard = 0;
        do begin
            @(negedge clk); acc = pix_ready;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("beat_accept_timeout", 32'(acc), 32'd1);
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic send_beat2(input logic p, input logic sof);
        logic acc;
        int   guard;
        pix_valid2 = 1'b1; pix_in2 = p; pix_sof2 = sof;
        guard = 0;
        do begin
            @(negedge clk); acc = pix_ready2;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("beat2_accept_timeout", 32'(acc), 32'd1);
        pix_valid2 = 1'b0; pix_sof2 = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v, input logic stall);
        for (int i = 0; i < 16; i++) begin
            send_beat(v.frame[i], i == 0);
            if (!stall) begin
                chk($sformatf("v%0d_valid_b%0d", id, i), 32'(win_valid),
                    32'((i / 4 >= 2) && (i % 4 >= 2)));
                chk($sformatf("v%0d_last_b%0d", id, i), 32'(win_last), 32'(i == 15));
            end
        end
        repeat (20) @(posedge clk);
        #1;
        chk($sformatf("v%0d_count", id), got_w.size(), 4);
        for (int k = 0; k < 4 && k < got_w.size(); k++) begin
            chk($sformatf("v%0d_win%0d", id, k), 32'(got_w[k]), 32'(v.w[k]));
            chk($sformatf("v%0d_last%0d", id, k), 32'(got_l[k]), 32'(k == 3));
`ifdef WIN_POPCOUNT_EN
            chk($sformatf("v%0d_pc%0d", id, k), 32'(got_pc[k]), $countones(v.w[k]));
`endif
        end
        got_w.delete(); got_l.delete(); got_pc.delete();
    endtask

    initial begin
        vec_t       tbl[7];
        logic       p2[784];
        logic [8:0] e2[$];
        logic [8:0] w;
        int         guard;

        tbl[0] = '{frame: 16'hFFFF, w: {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}};
        tbl[1] = '{frame: 16'hAAAA, w: {9'h16D, 9'h092, 9'h16D, 9'h092}};
        tbl[2] = '{frame: 16'h0000, w: {9'h000, 9'h000, 9'h000, 9'h000}};
        tbl[3] = '{frame: 16'h0020, w: {9'h001, 9'h002, 9'h008, 9'h010}};
        tbl[4] = '{frame: 16'h0400, w: {9'h010, 9'h020, 9'h080, 9'h100}};
        tbl[5] = '{frame: 16'hF000, w: {9'h1C0, 9'h1C0, 9'h000, 9'h000}};
        tbl[6] = '{frame: 16'h1111, w: {9'h000, 9'h049, 9'h000, 9'h049}};

        rst = 1'b0; ready_man = 1'b1; tog_mode = 1'b0;
        pix_in = 0; pix_valid = 0; pix_sof = 0;
        pix_in2 = 0; pix_valid2 = 0; pix_sof2 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_valid", 32'(win_valid), 0);
        chk("reset_out", 32'(win_out), 0);
        chk("reset_last", 32'(win_last), 0);
        chk("reset_pix_ready", 32'(pix_ready), 1);
`ifdef WIN_POPCOUNT_EN
        chk("reset_popcnt", 32'(win_popcnt), 0);
`endif

        for (int t = 0; t < 7; t++) run_vec(t, tbl[t], 1'b0);

        tog_mode = 1'b1;
        run_vec(10, tbl[1], 1'b1);
        tog_mode = 1'b0;
        chk("stall_seen", 32'(stall_seen > 0), 1);
        chk("stall_hold_bad", stall_bad, 0);

        for (int i = 0; i < 5; i++) send_beat(1'b1, 1'b0);
        chk("drop_no_window", 32'(win_valid), 0);
        run_vec(20, tbl[1], 1'b0);

        for (int i = 0; i < 6; i++) send_beat(tbl[0].frame[i], i == 0);
        run_vec(21, tbl[3], 1'b0);

        ready_man = 1'b0;
        for (int i = 0; i < 11; i++) send_beat(tbl[1].frame[i], i == 0);
        chk("rst_pre_valid", 32'(win_valid), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rst_mid_valid", 32'(win_valid), 0);
        chk("rst_mid_out", 32'(win_out), 0);
        chk("rst_mid_last", 32'(win_last), 0);
        got_w.delete(); got_l.delete(); got_pc.delete();
        ready_man = 1'b1;
        run_vec(30, tbl[4], 1'b0);
        chk("stall_hold_bad_final", stall_bad, 0);

        for (int i = 0; i < 784; i++) p2[i] = 1'($urandom_range(0, 1));
        for (int r = 2; r < 28; r++) begin
            for (int c = 2; c < 28; c++) begin
                w = '0;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        w[3*wr + wc] = p2[(r - 2 + wr) * 28 + (c - 2 + wc)];
                e2.push_back(w);
            end
        end
        for (int i = 0; i < 784; i++) begin
            while ($urandom_range(0, 99) >= 70) begin
                @(posedge clk); #1;
            end
            send_beat2(p2[i], i == 0);
        end
        guard = 0;
        while (got_w2.size() < 676 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("rand_count", got_w2.size(), 676);
        for (int k = 0; k < 676 && k < got_w2.size(); k++) begin
            chk($sformatf("rand_win%0d", k), 32'(got_w2[k]), 32'(e2[k]));
            chk($sformatf("rand_last%0d", k), 32'(got_l2[k]), 32'(k == 675));
`ifdef WIN_POPCOUNT_EN
            chk($sformatf("rand_pc%0d", k), 32'(got_pc2[k]), $countones(e2[k]));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
